// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch FSM driving imem req/gnt/rvalid and the PC stall.
// FETCH_PERF_CNT_EN adds a saturating stall-cycle counter output (stall_cycles_o).
module if_fetch_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush,
    input  logic            id_stall,
    output logic            stall_o,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles_o
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ADV, DRAIN} state_t;
    state_t          r_state, w_next;
    logic [XLEN-1:0] r_addr_q;
    assign stall_o   = r_state != ADV;
    assign imem_req  = r_state == REQ;
    assign imem_addr = imem_req ? pc_i : '0;
    always_comb begin
        w_next = r_state;
        if (flush) begin
            // a granted-but-unanswered request must be drained before advancing
            case (r_state)
                REQ:     w_next = imem_gnt ? DRAIN : ADV;
                WAIT:    w_next = imem_rvalid ? ADV : DRAIN;
                DRAIN:   w_next = DRAIN;
                default: w_next = ADV;
            endcase
        end else begin
            case (r_state)
                IDLE:    w_next = REQ;
                REQ:     w_next = imem_gnt ? WAIT : REQ;
                WAIT:    w_next = imem_rvalid ? HOLD : WAIT;
                HOLD:    w_next = id_stall ? HOLD : ADV;
                ADV:     w_next = REQ;
                DRAIN:   w_next = imem_rvalid ? ADV : DRAIN;
                default: w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_addr_q      <= '0;
            instr_o       <= NOP_INSTR;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == REQ && imem_gnt)
                r_addr_q <= pc_i;
            if (flush) begin
                instr_valid_o <= 1'b0;
                instr_o       <= NOP_INSTR;
            end else if (r_state == WAIT && imem_rvalid) begin
                instr_o       <= imem_rdata;
                instr_pc_o    <= r_addr_q;
                instr_valid_o <= 1'b1;
            end else if (r_state == HOLD && !id_stall) begin
                instr_valid_o <= 1'b0;
            end
        end
    end
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    assign stall_cycles_o = r_stall_cycles;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (stall_o && r_stall_cycles != 32'hFFFF_FFFF)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: scoreboard bench; the bench also plays the PC register and instruction memory.
module tb_if_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h00000013;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, id_stall = 1'b0;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0, pc, imem_addr, instr_o, instr_pc_o, tgt = '0;
    logic        stall_o, imem_req, instr_valid_o, redir = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
`endif
    ent_t        sb[$];
    logic [31:0] exp_pc;
    int          errors = 0, checks = 0;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_i(pc), .flush(flush), .id_stall(id_stall),
        .stall_o(stall_o), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o)
`ifdef FETCH_PERF_CNT_EN
        , .stall_cycles_o(stall_cycles_o)
`endif
    );

    always #5 clk = ~clk;

    // PC register model: advances (or takes the redirect target) only when not stalled
    always @(posedge clk)
        if (rst) pc <= '0;
        else if (!stall_o) pc <= redir ? tgt : pc + 32'd4;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        checks++; if (instr_o !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instr_o, NOP); end
        checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", stall_o); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL rst_perf: got %0d want 0", stall_cycles_o); end
`endif
        rst = 1'b0;
        exp_pc = 32'h0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_req: got %b want 1", imem_req); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (stall_cycles_o !== 32'd1) begin errors++; $display("FAIL perf_first: got %0d want 1", stall_cycles_o); end
`endif
    endtask

    // One full fetch: gd cycles before gnt, rd cycles between gnt and rvalid, hs id_stall cycles in HOLD
    task automatic do_fetch(input int gd, input int rd, input logic [31:0] data, input int hs);
        ent_t e;
        logic [31:0] a;
        int n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_timeout: got %b want 1", imem_req); end
        a = imem_addr;
        checks++; if (a !== exp_pc) begin errors++; $display("FAIL req_addr: got %h want %h", a, exp_pc); end
        for (int i = 0; i < gd; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== a || stall_o !== 1'b1) begin errors++; $display("FAIL req_hold: req=%b addr=%h stall=%b want 1 %h 1", imem_req, imem_addr, stall_o, a); end
            tick();
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < rd; i++) begin
            checks++; if (imem_req !== 1'b0 || stall_o !== 1'b1 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL wait: req=%b stall=%b valid=%b want 0 1 0", imem_req, stall_o, instr_valid_o); end
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata = data;
        sb.push_back('{pc: a, instr: data});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        e = sb.pop_front();
        checks++; if (instr_valid_o !== 1'b1 || instr_o !== e.instr || instr_pc_o !== e.pc) begin errors++; $display("FAIL capture: valid=%b instr=%h pc=%h want 1 %h %h", instr_valid_o, instr_o, instr_pc_o, e.instr, e.pc); end
        id_stall = hs > 0;
        for (int i = 0; i < hs; i++) begin
            tick();
            checks++; if (instr_valid_o !== 1'b1 || instr_o !== e.instr || instr_pc_o !== e.pc || stall_o !== 1'b1) begin errors++; $display("FAIL hold: valid=%b instr=%h pc=%h stall=%b want 1 %h %h 1", instr_valid_o, instr_o, instr_pc_o, stall_o, e.instr, e.pc); end
        end
        id_stall = 1'b0;
        tick();
        checks++; if (stall_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL adv: stall=%b valid=%b want 0 0", stall_o, instr_valid_o); end
        exp_pc = exp_pc + 32'd4;
        tick();
        checks++; if (stall_o !== 1'b1 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL next_req: stall=%b req=%b addr=%h want 1 1 %h", stall_o, imem_req, imem_addr, exp_pc); end
    endtask

    task automatic test_basic;
        do_fetch(0, 0, 32'h00500093, 0);
    endtask

    task automatic test_back_to_back;
        do_fetch(0, 0, 32'h00A00113, 0);
        do_fetch(0, 0, 32'h002081B3, 0);
    endtask

    task automatic test_slow_mem;
        do_fetch(3, 2, 32'h40110233, 0);
    endtask

    task automatic test_id_stall;
        do_fetch(0, 0, 32'h00312023, 5);
    endtask

    task automatic test_flush_wait;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush = 1'b1;
        redir = 1'b1;
        tgt = 32'h100;
        tick();
        flush = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || stall_o !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL fw_drain: valid=%b instr=%h stall=%b req=%b want 0 %h 1 0", instr_valid_o, instr_o, stall_o, imem_req, NOP); end
        tick();
        checks++; if (stall_o !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL fw_drain2: stall=%b req=%b want 1 0", stall_o, imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (stall_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== NOP) begin errors++; $display("FAIL fw_adv: stall=%b valid=%b instr=%h want 0 0 %h", stall_o, instr_valid_o, instr_o, NOP); end
        tick();
        redir = 1'b0;
        exp_pc = 32'h100;
        checks++; if (stall_o !== 1'b1 || imem_addr !== exp_pc || instr_o !== NOP) begin errors++; $display("FAIL fw_target: stall=%b addr=%h instr=%h want 1 %h %h", stall_o, imem_addr, instr_o, exp_pc, NOP); end
        do_fetch(0, 1, 32'h06400513, 0);
    endtask

    task automatic test_flush_rvalid;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BADF00D;
        flush = 1'b1;
        redir = 1'b1;
        tgt = 32'h200;
        tick();
        imem_rvalid = 1'b0;
        flush = 1'b0;
        checks++; if (stall_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== NOP) begin errors++; $display("FAIL fr_adv: stall=%b valid=%b instr=%h want 0 0 %h", stall_o, instr_valid_o, instr_o, NOP); end
        tick();
        redir = 1'b0;
        exp_pc = 32'h200;
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL fr_target: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc); end
        do_fetch(1, 0, 32'h00000513, 0);
    endtask

    task automatic test_flush_gnt;
        imem_gnt = 1'b1;
        flush = 1'b1;
        redir = 1'b1;
        tgt = 32'h300;
        tick();
        imem_gnt = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b0 || stall_o !== 1'b1 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL fg_drain: req=%b stall=%b valid=%b want 0 1 0", imem_req, stall_o, instr_valid_o); end
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h12345678;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (stall_o !== 1'b0 || instr_o !== NOP) begin errors++; $display("FAIL fg_adv: stall=%b instr=%h want 0 %h", stall_o, instr_o, NOP); end
        tick();
        redir = 1'b0;
        exp_pc = 32'h300;
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL fg_target: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_pc); end
        do_fetch(0, 0, 32'hFFF00093, 0);
    endtask

    task automatic test_reset_mid;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || instr_pc_o !== 32'h0 || stall_o !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_reset: valid=%b instr=%h pc=%h stall=%b req=%b addr=%h want 0 %h 0 1 0 0", instr_valid_o, instr_o, instr_pc_o, stall_o, imem_req, imem_addr, NOP); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL rm_perf0: got %0d want 0", stall_cycles_o); end
`endif
        imem_rvalid = 1'b1;
        imem_rdata = 32'hCAFEBABE;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (instr_valid_o !== 1'b0 || instr_o !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_late: valid=%b instr=%h req=%b addr=%h want 0 %h 1 0", instr_valid_o, instr_o, imem_req, imem_addr, NOP); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (stall_cycles_o !== 32'd1) begin errors++; $display("FAIL rm_perf1: got %0d want 1", stall_cycles_o); end
        tick();
        checks++; if (stall_cycles_o !== 32'd2) begin errors++; $display("FAIL rm_perf2: got %0d want 2", stall_cycles_o); end
`endif
        exp_pc = 32'h0;
        do_fetch(0, 0, 32'h00100073, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_slow_mem();
        test_id_stall();
        test_flush_wait();
        test_flush_rvalid();
        test_flush_gnt();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_empty: got %0d entries want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller that consumes the fetch address from the PC register (`pc_i` ← PC `pc_o`) and generates the PC's `stall` input (`stall_o` → PC `stall`).
- Issues requests to instruction memory over a req/gnt/rvalid handshake and captures the returned instruction into the IF/ID-side output register.
- Holds the PC until each fetch completes and the decode stage has accepted it.
- Handles pipeline flush/redirect, including discarding an in-flight memory response.

Parameters:
- XLEN, 32, address/instruction width.
- NOP_INSTR, 32'h00000013, value driven on `instr_o` at reset and after flush (`addi x0,x0,0`).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_i  input  XLEN  current fetch address from the PC register.
- flush  input  1  redirect/flush from the branch unit, single-cycle pulse.
- id_stall  input  1  decode stage cannot accept an instruction this cycle.
- stall_o  output  1  to the PC register; 0 lets the PC load its next value at the end of the cycle.
- imem_req  output  1  memory request valid.
- imem_addr  output  XLEN  memory request address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; at most one outstanding request.
- imem_rdata  input  XLEN  response instruction word.
- instr_o  output  XLEN  fetched instruction.
- instr_pc_o  output  XLEN  address of `instr_o`.
- instr_valid_o  output  1  `instr_o` is valid for decode.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, ADV, DRAIN. Registered state; `stall_o = (state != ADV)` is decoded from state.
- Reset (`rst=1` at a rising edge; overrides everything, including mid-transaction):
  - state=IDLE, instr_o=NOP_INSTR, instr_pc_o=0, instr_valid_o=0, addr_q=0.
  - imem_req=0, imem_addr=0, stall_o=1.
  - Any response arriving after reset is ignored, because IDLE/REQ do not sample rvalid.
- IDLE: always goes to REQ on the next cycle.
- REQ:
  - Drives imem_req=1 and imem_addr=pc_i. pc_i is stable because stall_o=1.
  - On imem_gnt: addr_q<=pc_i, go to WAIT.
  - imem_req stays asserted until granted.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: instr_o<=imem_rdata, instr_pc_o<=addr_q, instr_valid_o<=1, go to HOLD.
  - The earliest rvalid is the cycle after gnt.
- HOLD:
  - Instruction presented with instr_valid_o=1.
  - If id_stall=0, the instruction is consumed at this edge: instr_valid_o<=0, go to ADV.
  - Otherwise stay in HOLD with outputs stable.
- ADV:
  - stall_o=0 for exactly one cycle; the PC loads its next value at the end of this cycle.
  - Then go to REQ, which issues the new pc_i.
- Best-case throughput: one instruction per 4 cycles (REQ→WAIT→HOLD→ADV).
- Flush (checked after reset, before all other transitions):
  - instr_valid_o<=0, instr_o<=NOP_INSTR.
  - From IDLE, HOLD or ADV: go to ADV.
  - From REQ without gnt: drop the request and go to ADV.
  - From REQ with gnt in the same cycle: the request is outstanding, so go to DRAIN.
  - From WAIT without rvalid: go to DRAIN.
  - From WAIT with rvalid in the same cycle: discard the data and go to ADV.
  - From DRAIN: stay in DRAIN.
- DRAIN: stall_o=1 and imem_req=0. On imem_rvalid, discard the data (outputs unchanged) and go to ADV.
- Redirect contract: the branch unit holds the target on pc_i until it observes stall_o=0, so the PC loads the target during ADV.
- Outputs are registered except stall_o, imem_req and imem_addr, which are decoded from state/pc_i. No combinational path from imem_rdata to any output.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output port `stall_cycles_o [31:0]`.
  - Counts rising edges at which `stall_o=1` and `rst=0`.
  - Saturates at 32'hFFFFFFFF; cleared to 0 by rst; not cleared by flush.
- Undefined: no port, no counter logic; behaviour otherwise identical.

Test Plan:
- Basic fetch, zero-wait memory, pc_i=0x0, rdata=0x00500093 (gnt same cycle as req, rvalid next cycle), id_stall=0 → instr_o=0x00500093, instr_pc_o=0x0, instr_valid_o=1 for one cycle; stall_o=0 exactly one cycle later; next request issues with imem_addr=0x4.
- Slow grant (gnt delayed 3 cycles) and rvalid delayed 2 cycles → imem_req held high for 4 cycles at constant imem_addr; stall_o stays 1 throughout; instruction captured exactly once.
- id_stall=1 for 5 cycles while in HOLD → instr_o/instr_pc_o/instr_valid_o stable for all 5 cycles; stall_o=1; ADV occurs the cycle after id_stall drops.
- Flush in WAIT, then rvalid with rdata=0xDEADBEEF 2 cycles later → data discarded: instr_valid_o=0, instr_o=0x00000013; one stall_o=0 cycle after the drained rvalid; next imem_addr=redirect target 0x100.
- Corner cases:
  - Flush with rvalid in the same WAIT cycle → data discarded, ADV next cycle.
  - Flush with gnt in the same REQ cycle → DRAIN entered; no second request issued until rvalid.
- rst=1 asserted for one cycle mid-WAIT → all outputs return to reset values; the late rvalid is ignored. With FETCH_PERF_CNT_EN, stall_cycles_o=0 after reset and increments every stalled cycle.
